seq_pattern_tx: RTL and testbench

Serial pattern transmitter, the generating end of the team's serial sequence-detector interface.
- Captures a parallel pattern, length and repeat count on a start strobe.
- Shifts the pattern out MSB-first, one bit per clk, with a valid qualifier.
- Signals completion with a one-cycle done pulse.
- Used as the stimulus source on the detector's serial input and as a stand-alone serial pattern generator.

---
 rtl/seq_pkg.sv | 16 +
 rtl/seq_tx_shreg.sv | 64 ++++++
 rtl/seq_pattern_tx.sv | 143 ++++++++++++++
 tb/tb_seq_pattern_tx.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence transmitter/detector pair:
// FSM state encoding and default widths.
package seq_pkg;

  localparam int unsigned SEQ_PAT_W = 8;
  localparam int unsigned SEQ_LEN_W = 4;
  localparam int unsigned SEQ_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/seq_tx_shreg.sv
// Loadable pattern shift register: aligns bit [L-1] to the MSB on load,
// shifts one bit per request and tracks the index of the current bit.
module seq_tx_shreg
  import seq_pkg::*;
#(
  parameter int PAT_W = SEQ_PAT_W,
  parameter int LEN_W = SEQ_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             reload,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len_eff,
  output logic             bit_nxt,
  output logic [LEN_W-1:0] idx_nxt,
  output logic [LEN_W-1:0] idx_cur
);

  logic [PAT_W-1:0] cap_q, cap_d;
  logic [PAT_W-1:0] work_q, work_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_q  <= '0;
      work_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
    end else begin
      cap_q  <= cap_d;
      work_q <= work_d;
      len_q  <= len_d;
      idx_q  <= idx_d;
    end
  end

  // Left-justify the pattern so bit [L-1] is always the MSB of the register.
  always_comb begin
    cap_d  = cap_q;
    work_d = work_q;
    len_d  = len_q;
    idx_d  = idx_q;
    if (load) begin
      cap_d  = pattern << (LEN_W'(PAT_W) - len_eff);
      work_d = cap_d;
      len_d  = len_eff;
      idx_d  = (len_eff != '0) ? len_eff - LEN_W'(1) : '0;
    end else if (reload) begin
      work_d = cap_q;
      idx_d  = len_q - LEN_W'(1);
    end else if (shift) begin
      work_d = work_q << 1;
      idx_d  = (idx_q != '0) ? idx_q - LEN_W'(1) : '0;
    end
  end

  assign bit_nxt = work_d[PAT_W-1];
  assign idx_nxt = idx_d;
  assign idx_cur = idx_q;

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: MSB-first, len bits per repetition, reps copies.
// Define SEQ_TX_GAP_EN to insert one idle GAP cycle between repetitions.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int PAT_W = SEQ_PAT_W,
  parameter int LEN_W = SEQ_LEN_W,
  parameter int CNT_W = SEQ_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] reps,
  output logic             sd,
  output logic             sd_vld,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] bit_idx
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic             sd_q, sd_d;
  logic             sd_vld_q, sd_vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] bit_idx_q, bit_idx_d;

  logic             load, shift, reload;
  logic [LEN_W-1:0] len_eff;
  logic             bit_nxt;
  logic [LEN_W-1:0] idx_nxt, idx_cur;

  assign len_eff = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;

  seq_tx_shreg #(
    .PAT_W(PAT_W),
    .LEN_W(LEN_W)
  ) u_shreg (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .shift  (shift),
    .reload (reload),
    .pattern(pattern),
    .len_eff(len_eff),
    .bit_nxt(bit_nxt),
    .idx_nxt(idx_nxt),
    .idx_cur(idx_cur)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      rep_q     <= '0;
      sd_q      <= 1'b0;
      sd_vld_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      rep_q     <= rep_d;
      sd_q      <= sd_d;
      sd_vld_q  <= sd_vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  // rep_q counts repetitions still to send, including the current one.
  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    load    = 1'b0;
    shift   = 1'b0;
    reload  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          rep_d   = (reps == '0) ? CNT_W'(1) : reps;
          state_d = (len_eff == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (idx_cur == '0) begin
          if (rep_q > CNT_W'(1)) begin
            rep_d = rep_q - CNT_W'(1);
`ifdef SEQ_TX_GAP_EN
            state_d = ST_GAP;
`else
            reload  = 1'b1;
            state_d = ST_SHIFT;
`endif
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          shift = 1'b1;
        end
      end
`ifdef SEQ_TX_GAP_EN
      ST_GAP: begin
        reload  = 1'b1;
        state_d = ST_SHIFT;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes from a flop.
  always_comb begin
    sd_d      = 1'b0;
    sd_vld_d  = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    bit_idx_d = '0;
    case (state_d)
      ST_SHIFT: begin
        sd_d      = bit_nxt;
        sd_vld_d  = 1'b1;
        busy_d    = 1'b1;
        bit_idx_d = idx_nxt;
      end
      ST_GAP:  busy_d = 1'b1;
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  assign sd      = sd_q;
  assign sd_vld  = sd_vld_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign bit_idx = bit_idx_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx; observed word per cycle is
// {sd, sd_vld, busy, done, bit_idx[3:0]}. Honours SEQ_TX_GAP_EN.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic [3:0] reps = '0;
  logic       sd, sd_vld, busy, done;
  logic [3:0] bit_idx;
  logic [7:0] obs;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;

  seq_pattern_tx #(
    .PAT_W(8),
    .LEN_W(4),
    .CNT_W(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .pattern(pattern),
    .len    (len),
    .reps   (reps),
    .sd     (sd),
    .sd_vld (sd_vld),
    .busy   (busy),
    .done   (done),
    .bit_idx(bit_idx)
  );

  assign obs = {sd, sd_vld, busy, done, bit_idx};

  function automatic logic [7:0] ev(logic s, logic v, logic b, logic d, logic [3:0] i);
    return {s, v, b, d, i};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(logic [7:0] p, logic [3:0] l, logic [3:0] r);
    pattern = p;
    len     = l;
    reps    = r;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    total_cnt++;
    if (obs !== 8'h00) $display("FAIL reset_held: got %b required %b", obs, 8'h00);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    step();
    total_cnt++;
    if (obs !== 8'h00) $display("FAIL reset_release: got %b required %b", obs, 8'h00);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [7:0] pat = 8'b1011_0010;
    logic [7:0] e;
    kick(pat, 4'd8, 4'd1);
    for (int c = 1; c <= 10; c++) begin
      if (c <= 8) e = ev(pat[8-c], 1'b1, 1'b1, 1'b0, 4'(8 - c));
      else if (c == 9) e = ev(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      else e = 8'h00;
      total_cnt++;
      if (obs !== e) $display("FAIL basic_b2 c%0d: got %b required %b", c, obs, e);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_repeat();
    logic [2:0] b = 3'b101;
    logic [7:0] e;
    int         last;
    kick(8'h05, 4'd3, 4'd2);
`ifdef SEQ_TX_GAP_EN
    last = 9;
`else
    last = 8;
`endif
    for (int c = 1; c <= last; c++) begin
`ifdef SEQ_TX_GAP_EN
      if (c <= 3) e = ev(b[3-c], 1'b1, 1'b1, 1'b0, 4'(3 - c));
      else if (c == 4) e = ev(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      else if (c <= 7) e = ev(b[7-c], 1'b1, 1'b1, 1'b0, 4'(7 - c));
      else if (c == 8) e = ev(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      else e = 8'h00;
`else
      if (c <= 3) e = ev(b[3-c], 1'b1, 1'b1, 1'b0, 4'(3 - c));
      else if (c <= 6) e = ev(b[6-c], 1'b1, 1'b1, 1'b0, 4'(6 - c));
      else if (c == 7) e = ev(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      else e = 8'h00;
`endif
      total_cnt++;
      if (obs !== e) $display("FAIL repeat_05x2 c%0d: got %b required %b", c, obs, e);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_zero_len();
    logic [7:0] e;
    kick(8'hFF, 4'd0, 4'd5);
    for (int c = 1; c <= 3; c++) begin
      e = (c == 1) ? ev(1'b0, 1'b0, 1'b0, 1'b1, 4'd0) : 8'h00;
      total_cnt++;
      if (obs !== e) $display("FAIL zero_len c%0d: got %b required %b", c, obs, e);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_clamp();
    logic [7:0] e;
    kick(8'hFF, 4'd12, 4'd0);
    for (int c = 1; c <= 10; c++) begin
      if (c <= 8) e = ev(1'b1, 1'b1, 1'b1, 1'b0, 4'(8 - c));
      else if (c == 9) e = ev(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      else e = 8'h00;
      total_cnt++;
      if (obs !== e) $display("FAIL clamp_len12 c%0d: got %b required %b", c, obs, e);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_ignore_start();
    logic [7:0] pat = 8'b1011_0010;
    logic [7:0] e;
    kick(pat, 4'd8, 4'd1);
    for (int c = 1; c <= 11; c++) begin
      if (c <= 8) e = ev(pat[8-c], 1'b1, 1'b1, 1'b0, 4'(8 - c));
      else if (c == 9) e = ev(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      else e = 8'h00;
      total_cnt++;
      if (obs !== e) $display("FAIL ignore_start c%0d: got %b required %b", c, obs, e);
      else pass_cnt++;
      if (c == 4) begin
        pattern = 8'h4D;
        len     = 4'd3;
        reps    = 4'd3;
      end else if (c == 9) begin
        pattern = 8'hFF;
        len     = 4'd8;
        reps    = 4'd1;
      end
      start = (c == 4) || (c == 9);
      step();
      start = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] t[1:9];
    t[1] = ev(1'b1, 1'b1, 1'b1, 1'b0, 4'd2);
    t[2] = ev(1'b0, 1'b1, 1'b1, 1'b0, 4'd1);
    t[3] = ev(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    t[4] = ev(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    t[5] = 8'h00;
    t[6] = ev(1'b1, 1'b1, 1'b1, 1'b0, 4'd1);
    t[7] = ev(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    t[8] = ev(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    t[9] = 8'h00;
    kick(8'h05, 4'd3, 4'd1);
    for (int c = 1; c <= 9; c++) begin
      total_cnt++;
      if (obs !== t[c]) $display("FAIL back_to_back c%0d: got %b required %b", c, obs, t[c]);
      else pass_cnt++;
      if (c == 5) begin
        pattern = 8'h02;
        len     = 4'd2;
        reps    = 4'd1;
      end
      start = (c == 5);
      step();
      start = 1'b0;
    end
  endtask

  task automatic test_max_reps();
    logic [7:0] e;
    int         last;
    kick(8'h01, 4'd1, 4'd15);
`ifdef SEQ_TX_GAP_EN
    last = 31;
`else
    last = 17;
`endif
    for (int c = 1; c <= last; c++) begin
`ifdef SEQ_TX_GAP_EN
      if (c <= 29) e = (c % 2 == 1) ? ev(1'b1, 1'b1, 1'b1, 1'b0, 4'd0)
                                    : ev(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      else if (c == 30) e = ev(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      else e = 8'h00;
`else
      if (c <= 15) e = ev(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      else if (c == 16) e = ev(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      else e = 8'h00;
`endif
      total_cnt++;
      if (obs !== e) $display("FAIL max_reps c%0d: got %b required %b", c, obs, e);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] t[1:5];
    kick(8'hB2, 4'd8, 4'd1);
    step();
    step();
    step();
    total_cnt++;
    if (obs !== ev(1'b1, 1'b1, 1'b1, 1'b0, 4'd4))
      $display("FAIL rst_mid_pre: got %b required %b", obs, ev(1'b1, 1'b1, 1'b1, 1'b0, 4'd4));
    else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    total_cnt++;
    if (obs !== 8'h00) $display("FAIL rst_mid_async: got %b required %b", obs, 8'h00);
    else pass_cnt++;
    step();
    @(negedge clk);
    rst = 1'b1;
    step();
    total_cnt++;
    if (obs !== 8'h00) $display("FAIL rst_mid_after: got %b required %b", obs, 8'h00);
    else pass_cnt++;
    t[1] = ev(1'b1, 1'b1, 1'b1, 1'b0, 4'd2);
    t[2] = ev(1'b0, 1'b1, 1'b1, 1'b0, 4'd1);
    t[3] = ev(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    t[4] = ev(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    t[5] = 8'h00;
    kick(8'h05, 4'd3, 4'd1);
    for (int c = 1; c <= 5; c++) begin
      total_cnt++;
      if (obs !== t[c]) $display("FAIL rst_mid_fresh c%0d: got %b required %b", c, obs, t[c]);
      else pass_cnt++;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_repeat();
    test_zero_len();
    test_clamp();
    test_ignore_start();
    test_back_to_back();
    test_max_reps();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
